// File: rtl/nibble_serializer.sv
// Nibble-serial producer: streams a weight operand one nibble per beat, LSB nibble first,
// tagging each beat with its index and a zero flag; optionally drops all-zero nibbles.
module nibble_serializer #(
  parameter int LOG2_WIDTH        = 4,
  parameter int WIDTH             = 2**LOG2_WIDTH,
  parameter int LOG2_NIBBLE_WIDTH = 2,
  parameter int NIBBLE_WIDTH      = 2**LOG2_NIBBLE_WIDTH,
  parameter int NUM_NIB           = WIDTH/NIBBLE_WIDTH,
  parameter int IDX_W             = ((LOG2_WIDTH-LOG2_NIBBLE_WIDTH) > 1) ?
                                    (LOG2_WIDTH-LOG2_NIBBLE_WIDTH) : 1,
  parameter bit SKIP_ZERO         = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NIBBLE_WIDTH-1:0] out_nibble,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_zero,
  output logic                    out_last,
  output logic                    busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic [NUM_NIB-1:0]      pending_q, pending_d;
  logic                    out_valid_q, out_valid_d;
  logic [NIBBLE_WIDTH-1:0] out_nibble_q, out_nibble_d;
  logic [IDX_W-1:0]        out_index_q, out_index_d;
  logic                    out_zero_q, out_zero_d;
  logic                    out_last_q, out_last_d;

  logic                    in_ready_s, load_s, handshake_s;
  logic [NUM_NIB-1:0]      raw_mask_s, mask_s, src_mask_s, rest_s;
  logic [WIDTH-1:0]        src_data_s;
  logic [IDX_W-1:0]        sel_idx_s;
  logic [NIBBLE_WIDTH-1:0] sel_nib_s;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_NIB-1:0] m);
    lowest_idx = '0;
    for (int i = NUM_NIB-1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDX_W'(i);
      else      lowest_idx = lowest_idx;
    end
  endfunction

  function automatic logic [NIBBLE_WIDTH-1:0] nibble_at(input logic [WIDTH-1:0] d,
                                                        input logic [IDX_W-1:0] idx);
    nibble_at = d[idx*NIBBLE_WIDTH +: NIBBLE_WIDTH];
  endfunction

  // Pending-nibble mask of an incoming operand; an all-zero operand still yields beat 0.
  always_comb begin
    raw_mask_s = '0;
    for (int i = 0; i < NUM_NIB; i++) begin
      raw_mask_s[i] = SKIP_ZERO ? (|in_data[i*NIBBLE_WIDTH +: NIBBLE_WIDTH]) : 1'b1;
    end
    mask_s = (raw_mask_s == '0) ? {{(NUM_NIB-1){1'b0}}, 1'b1} : raw_mask_s;
  end

  assign handshake_s = out_valid_q & out_ready;
  assign in_ready_s  = rst_n & ((state_q == IDLE) | (handshake_s & out_last_q));
  assign load_s      = in_valid & in_ready_s;

  // Next-state and next-beat selection.
  always_comb begin
    state_d      = state_q;
    data_d       = load_s ? in_data : data_q;
    pending_d    = pending_q;
    out_valid_d  = out_valid_q;
    out_nibble_d = out_nibble_q;
    out_index_d  = out_index_q;
    out_zero_d   = out_zero_q;
    out_last_d   = out_last_q;
    src_data_s   = load_s ? in_data : data_q;
    src_mask_s   = load_s ? mask_s : pending_q;
    sel_idx_s    = lowest_idx(src_mask_s);
    sel_nib_s    = nibble_at(src_data_s, sel_idx_s);
    rest_s       = src_mask_s & ~({{(NUM_NIB-1){1'b0}}, 1'b1} << sel_idx_s);
    if (load_s || (handshake_s && !out_last_q)) begin
      state_d      = SEND;
      pending_d    = rest_s;
      out_valid_d  = 1'b1;
      out_nibble_d = sel_nib_s;
      out_index_d  = sel_idx_s;
      out_zero_d   = (sel_nib_s == '0);
      out_last_d   = (rest_s == '0);
    end else if (handshake_s) begin
      // Last beat consumed with no follow-on operand.
      state_d      = IDLE;
      pending_d    = '0;
      out_valid_d  = 1'b0;
      out_nibble_d = '0;
      out_index_d  = '0;
      out_zero_d   = 1'b0;
      out_last_d   = 1'b0;
    end else begin
      state_d      = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      out_nibble_q <= '0;
      out_index_q  <= '0;
      out_zero_q   <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_nibble_q <= out_nibble_d;
      out_index_q  <= out_index_d;
      out_zero_q   <= out_zero_d;
      out_last_q   <= out_last_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_q;
  assign out_nibble = out_nibble_q;
  assign out_index  = out_index_q;
  assign out_zero   = out_zero_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q == SEND);

endmodule
